// File: rtl/sram_write_assembler_pkg.sv
// Shared types and default sizing for the scratchpad write assembler.
package scpad_pkg;

  localparam int unsigned DEF_NUM_SLOTS      = 4;
  localparam int unsigned DEF_BEATS_PER_LINE = 8;
  localparam int unsigned DEF_ELEMS_PER_BEAT = 4;
  localparam int unsigned DEF_ELEM_W         = 16;
  localparam int unsigned DEF_ADDR_W         = 10;
  localparam int unsigned DEF_XBAR_W         = 32;

  localparam int unsigned DEF_SLOT_W = $clog2(DEF_NUM_SLOTS);
  localparam int unsigned DEF_BIDX_W = $clog2(DEF_BEATS_PER_LINE);
  localparam int unsigned DEF_ROW_W  = DEF_BEATS_PER_LINE * DEF_ELEMS_PER_BEAT * DEF_ELEM_W;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } wr_asm_state_e;

  // Slot record at the default sizing; parameterized instances build the same layout locally.
  typedef struct packed {
    wr_asm_state_e                 state;
    logic [DEF_BEATS_PER_LINE-1:0] beat_mask;
    logic [DEF_BIDX_W:0]           num_beats;
    logic [DEF_ADDR_W-1:0]         spad_addr;
    logic [DEF_XBAR_W-1:0]         xbar;
    logic [DEF_ROW_W-1:0]          wdata;
  } wr_asm_slot_t;

endpackage

// File: rtl/sram_write_assembler_if.sv
// Alloc / DRAM-response / SRAM-write bundle; out_elem_mask exists only with SRAM_WR_ASM_ELEM_MASK_EN.
interface sram_write_assembler_if #(
  parameter int unsigned NUM_SLOTS      = scpad_pkg::DEF_NUM_SLOTS,
  parameter int unsigned BEATS_PER_LINE = scpad_pkg::DEF_BEATS_PER_LINE,
  parameter int unsigned ELEMS_PER_BEAT = scpad_pkg::DEF_ELEMS_PER_BEAT,
  parameter int unsigned ELEM_W         = scpad_pkg::DEF_ELEM_W,
  parameter int unsigned ADDR_W         = scpad_pkg::DEF_ADDR_W,
  parameter int unsigned XBAR_W         = scpad_pkg::DEF_XBAR_W
);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned BIDX_W = $clog2(BEATS_PER_LINE);
  localparam int unsigned BEAT_W = ELEMS_PER_BEAT * ELEM_W;
  localparam int unsigned ROW_W  = BEATS_PER_LINE * BEAT_W;

  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [BIDX_W:0]          alloc_num_beats;
  logic [ADDR_W-1:0]        alloc_spad_addr;
  logic [XBAR_W-1:0]        alloc_xbar;
  logic [SLOT_W-1:0]        alloc_tag;
  logic                     dram_res_valid;
  logic [SLOT_W+BIDX_W-1:0] dram_id;
  logic [BEAT_W-1:0]        dram_rddata;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_wdata;
  logic [ADDR_W-1:0]        out_spad_addr;
  logic [XBAR_W-1:0]        out_xbar;
  logic                     err_sticky;
`ifdef SRAM_WR_ASM_ELEM_MASK_EN
  logic [BEATS_PER_LINE*ELEMS_PER_BEAT-1:0] out_elem_mask;
`endif

  modport master (
    output alloc_valid, alloc_num_beats, alloc_spad_addr, alloc_xbar,
           dram_res_valid, dram_id, dram_rddata, out_ready,
    input  alloc_ready, alloc_tag, out_valid, out_wdata, out_spad_addr, out_xbar, err_sticky
`ifdef SRAM_WR_ASM_ELEM_MASK_EN
    , input out_elem_mask
`endif
  );

  modport slave (
    input  alloc_valid, alloc_num_beats, alloc_spad_addr, alloc_xbar,
           dram_res_valid, dram_id, dram_rddata, out_ready,
    output alloc_ready, alloc_tag, out_valid, out_wdata, out_spad_addr, out_xbar, err_sticky
`ifdef SRAM_WR_ASM_ELEM_MASK_EN
    , output out_elem_mask
`endif
  );

endinterface

// File: rtl/sram_write_assembler_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins; N must be a power of 2.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // Wraps naturally because the index width exactly spans N.
      cand = ptr + IDX_W'(i);
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/sram_write_assembler.sv
// Gathers out-of-order DRAM beats into scratchpad rows across NUM_SLOTS lines.
// Define SRAM_WR_ASM_ELEM_MASK_EN to add per-element write enables (out_elem_mask).
module sram_write_assembler #(
  parameter int unsigned NUM_SLOTS      = scpad_pkg::DEF_NUM_SLOTS,
  parameter int unsigned BEATS_PER_LINE = scpad_pkg::DEF_BEATS_PER_LINE,
  parameter int unsigned ELEMS_PER_BEAT = scpad_pkg::DEF_ELEMS_PER_BEAT,
  parameter int unsigned ELEM_W         = scpad_pkg::DEF_ELEM_W,
  parameter int unsigned ADDR_W         = scpad_pkg::DEF_ADDR_W,
  parameter int unsigned XBAR_W         = scpad_pkg::DEF_XBAR_W
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sram_write_assembler_if.slave bus
);
  import scpad_pkg::*;

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned BIDX_W = $clog2(BEATS_PER_LINE);
  localparam int unsigned BEAT_W = ELEMS_PER_BEAT * ELEM_W;
  localparam int unsigned ROW_W  = BEATS_PER_LINE * BEAT_W;
  localparam logic [BIDX_W:0] FULL_BEATS = (BIDX_W+1)'(BEATS_PER_LINE);

  typedef struct packed {
    wr_asm_state_e             state;
    logic [BEATS_PER_LINE-1:0] beat_mask;
    logic [BIDX_W:0]           num_beats;
    logic [ADDR_W-1:0]         spad_addr;
    logic [XBAR_W-1:0]         xbar;
    logic [ROW_W-1:0]          wdata;
  } slot_t;

  slot_t slots [NUM_SLOTS];
  logic [SLOT_W-1:0] rr_ptr;
  logic              err_q;

  logic [NUM_SLOTS-1:0] free_vec, ready_vec, out_gnt;
  logic [SLOT_W-1:0]    alloc_idx, out_idx;
  logic                 alloc_ok, out_any, alloc_fire, out_fire;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    alloc_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i]  = (slots[i].state == FREE);
      ready_vec[i] = (slots[i].state == READY);
    end
    for (int unsigned i = NUM_SLOTS; i > 0; i--)
      if (free_vec[i-1]) alloc_idx = SLOT_W'(i-1);
    alloc_ok = |free_vec;
  end

  rr_arbiter #(.N(NUM_SLOTS)) u_out_arb (
    .req      (ready_vec),
    .ptr      (rr_ptr),
    .gnt      (out_gnt),
    .gnt_idx  (out_idx),
    .gnt_valid(out_any)
  );

  assign alloc_fire = bus.alloc_valid && alloc_ok;
  assign out_fire   = out_any && bus.out_ready;

  logic [SLOT_W-1:0]         beat_slot;
  logic [BIDX_W-1:0]         beat_idx;
  wr_asm_state_e             tgt_state;
  logic [BEATS_PER_LINE-1:0] tgt_mask, need_mask, mask_next;
  logic [BIDX_W:0]           tgt_nb, beat_lim;
  logic                      beat_ok, beat_dup;

  always_comb begin
    beat_slot = bus.dram_id[BIDX_W +: SLOT_W];
    beat_idx  = bus.dram_id[BIDX_W-1:0];
    tgt_state = slots[beat_slot].state;
    tgt_mask  = slots[beat_slot].beat_mask;
    tgt_nb    = slots[beat_slot].num_beats;
    // Counts above the line length are treated as a full line so the slot can still complete.
    beat_lim  = (tgt_nb == '0 || tgt_nb > FULL_BEATS) ? FULL_BEATS : tgt_nb;
    need_mask = '0;
    for (int unsigned i = 0; i < BEATS_PER_LINE; i++)
      need_mask[i] = (i < 32'(beat_lim));
    beat_ok   = (tgt_state == FILLING) && ({1'b0, beat_idx} < beat_lim);
    beat_dup  = beat_ok && tgt_mask[beat_idx];
    mask_next = tgt_mask;
    mask_next[beat_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slots[i].state     <= FREE;
        slots[i].beat_mask <= '0;
        slots[i].num_beats <= '0;
        slots[i].spad_addr <= '0;
        slots[i].xbar      <= '0;
        slots[i].wdata     <= '0;
      end
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      // Output, alloc and beat slots are READY, FREE and FILLING respectively, so never collide.
      if (out_fire) begin
        slots[out_idx].state <= FREE;
        rr_ptr <= out_idx + SLOT_W'(1);
      end
      if (alloc_fire) begin
        slots[alloc_idx].state     <= FILLING;
        slots[alloc_idx].beat_mask <= '0;
        slots[alloc_idx].num_beats <= bus.alloc_num_beats;
        slots[alloc_idx].spad_addr <= bus.alloc_spad_addr;
        slots[alloc_idx].xbar      <= bus.alloc_xbar;
        slots[alloc_idx].wdata     <= '0;
      end
      if (bus.dram_res_valid && beat_ok) begin
        slots[beat_slot].wdata[beat_idx*BEAT_W +: BEAT_W] <= bus.dram_rddata;
        slots[beat_slot].beat_mask <= mask_next;
        if (mask_next == need_mask) slots[beat_slot].state <= READY;
      end
      if (bus.dram_res_valid && (!beat_ok || beat_dup)) err_q <= 1'b1;
    end
  end

  logic [ROW_W-1:0]  out_wdata_c;
  logic [ADDR_W-1:0] out_addr_c;
  logic [XBAR_W-1:0] out_xbar_c;

  always_comb begin
    out_wdata_c = '0;
    out_addr_c  = '0;
    out_xbar_c  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      if (out_gnt[i]) begin
        out_wdata_c = slots[i].wdata;
        out_addr_c  = slots[i].spad_addr;
        out_xbar_c  = slots[i].xbar;
      end
  end

`ifdef SRAM_WR_ASM_ELEM_MASK_EN
  logic [BEATS_PER_LINE*ELEMS_PER_BEAT-1:0] out_emask_c;

  always_comb begin
    out_emask_c = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++)
      if (out_gnt[i])
        for (int unsigned e = 0; e < BEATS_PER_LINE*ELEMS_PER_BEAT; e++)
          out_emask_c[e] = slots[i].beat_mask[e / ELEMS_PER_BEAT];
  end

  assign bus.out_elem_mask = out_emask_c;
`endif

  assign bus.alloc_ready   = alloc_ok;
  assign bus.alloc_tag     = alloc_idx;
  assign bus.out_valid     = out_any;
  assign bus.out_wdata     = out_wdata_c;
  assign bus.out_spad_addr = out_addr_c;
  assign bus.out_xbar      = out_xbar_c;
  assign bus.err_sticky    = err_q;

endmodule
